lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit that sits directly upstream of the 32-bit word data memory.
//  It turns CPU byte-addressed load/store requests (byte, half, word; signed
//  or unsigned loads) into word-wide data-memory read/write cycles.
//  Sub-word stores use a read-modify-write sequence.
//  It returns load data and an error flag for misaligned or illegal requests.
// PARAMETERS
//  A_WIDTH  8   word-address width of the data memory (byte address = A_WIDTH+2)
//  D_WIDTH  32  data width; the design is fixed to 32 (4 byte lanes)
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          synchronous, active-high reset
//  req_valid   in   1          CPU request present
//  req_ready   out  1          unit can accept; high only in IDLE
//  req_we      in   1          1=store, 0=load
//  req_size    in   2          00=byte 01=half 10=word 11=illegal
//  req_signed  in   1          sign-extend a sub-word load
//  req_addr    in   A_WIDTH+2  byte address
//  req_wdata   in   32         store data, right-aligned
//  resp_valid  out  1          one-cycle response pulse
//  resp_rdata  out  32         load result (0 for stores and errors)
//  resp_err    out  1          misaligned or illegal size; qualified by resp_valid
//  mem_we      out  1          memory write enable
//  mem_w_addr  out  A_WIDTH    memory write word address
//  mem_w_data  out  32         memory write data
//  mem_re      out  1          memory read enable
//  mem_r_addr  out  A_WIDTH    memory read word address
//  mem_r_data  in   32         memory read data, valid the cycle after mem_re
// BEHAVIOUR
//  - Reset (sync): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
//    mem_we and mem_re are 0 from the first cycle after the reset edge.
//    An in-flight transaction is dropped and gets no response.
//  - Accept: req_valid && req_ready at a rising edge. Request fields are
//    latched; later changes to the CPU inputs are ignored until the next accept.
//  - States: IDLE, RD, RD_WAIT, WR.
//  - mem_* outputs are combinational decodes of state and latched request only.
//    mem_re=1 only in RD; mem_we=1 only in WR.
//    mem_w_addr = mem_r_addr = addr[A_WIDTH+1:2].
//  - Error (size=11; half with addr[0]=1; word with addr[1:0]!=0):
//    IDLE->IDLE, no memory access.
//    Next cycle: resp_valid=1, resp_err=1, resp_rdata=0.
//  - Load: IDLE->RD->RD_WAIT->IDLE.
//    In RD_WAIT, lane-select mem_r_data little-endian by addr[1:0], then zero-
//    or sign-extend into the resp_rdata register.
//    resp_valid=1 in the cycle after RD_WAIT; latency = 3 edges from accept.
//  - Word store: IDLE->WR->IDLE. mem_w_data = req_wdata.
//    resp_valid=1 one cycle after WR.
//  - Sub-word store: IDLE->RD->RD_WAIT->WR->IDLE.
//    In RD_WAIT, merge the new byte or half into mem_r_data at the lane given
//    by addr[1:0], and register the result as the write word.
//    In WR, mem_w_data = the merged word. Other lanes must be unchanged.
//  - req_ready = (state==IDLE). Back-to-back accept is allowed in the same cycle
//    as resp_valid, because the state is IDLE then.
//  - resp_valid is a single-cycle pulse; there is no backpressure on responses.
//  - Top word address wraps naturally; there is no bounds check.
// STRUCTURE
//  - Shared package lsu_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD and the
//    state enum.
//  - Sub-module lsu_lane_fmt (combinational):
//    load extract + sign/zero extend, and store lane merge.
//  - FSM and registers live in lsu_mem_ctrl.
// TESTING (bench pairs this block with the word data memory model)
//  1. Pre-load word 5 = 32'h8899AABB. Load byte, signed, addr 0x16.
//     -> resp_rdata=32'hFFFFFF99 three edges after accept.
//     Repeat unsigned -> 32'h00000099.
//  2. Store half 16'h1234 at 0x16 over 32'h8899AABB.
//     -> exactly one mem_we pulse, word 5 = 32'h1234AABB.
//     resp_valid arrives 4 edges after accept.
//  3. Store word 32'hDEADBEEF at 0x08.
//     -> mem_we in the cycle after accept, word 2 updated, resp_err=0.
//  4. Word load at 0x0A, half store at 0x03, size=11.
//     -> each gives resp_err=1, resp_rdata=0, with no mem_re or mem_we activity.
//  5. Assert rst during RD_WAIT of a sub-word store.
//     -> no mem_we, memory unchanged, no resp_valid, req_ready=1 next cycle.
//  6. Back-to-back: store byte 0x5A at 0x10, then load word 0x10 issued the
//     cycle resp_valid rises.
//     -> load returns the updated word; req_ready is never high outside IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the request legality check.
// No ports; imported by lsu_lane_fmt and lsu_mem_ctrl.
package lsu_pkg;

  localparam int unsigned LSU_D_WIDTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD      = 2'd1,
    S_RD_WAIT = 2'd2,
    S_WR      = 2'd3
  } state_e;

  // Misaligned half/word or the reserved size encoding.
  function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lo[0];
      SZ_WORD: err = (lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatter: extracts and zero/sign-extends sub-word load data and
// merges sub-word store data into a word read from memory.
// Latency: purely combinational. Backpressure: none.
// Ports: i_size/i_signed/i_lane describe the access, i_rdata is the memory
//        word, i_wdata the right-aligned store data; o_load is the formatted
//        load result, o_merge the word to write back.
import lsu_pkg::*;

module lsu_lane_fmt (
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [4:0]  w_sh;
  logic [31:0] w_shift;
  logic [31:0] w_mask;

  // Little-endian: lane n occupies bits [8n+7:8n].
  assign w_sh    = {i_lane, 3'b000};
  assign w_shift = i_rdata >> w_sh;

  always_comb begin
    o_load  = w_shift;  // word accesses are aligned, so the shift is zero
    o_merge = i_wdata;
    w_mask  = '0;
    case (i_size)
      SZ_BYTE: begin
        o_load  = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
        w_mask  = 32'h0000_00FF << w_sh;
        o_merge = (i_rdata & ~w_mask) | ((i_wdata & 32'h0000_00FF) << w_sh);
      end
      SZ_HALF: begin
        o_load  = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
        w_mask  = 32'h0000_FFFF << w_sh;
        o_merge = (i_rdata & ~w_mask) | ((i_wdata & 32'h0000_FFFF) << w_sh);
      end
      default: begin
        o_load  = w_shift;
        o_merge = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a 32-bit word memory (byte/half/word, RMW for sub-word stores).
// Latency from accept edge: error 1, word store 2, load 3, sub-word store 4 edges to resp_valid.
// Backpressure: req_ready only in IDLE; responses are single-cycle pulses with no backpressure.
// Ports: clk/rst (sync, active high); req_* CPU request; resp_* response pulse;
//        mem_* word-memory read/write port (read data valid the cycle after mem_re).
import lsu_pkg::*;

module lsu_mem_ctrl #(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned D_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [A_WIDTH+1:0]   req_addr,
  input  logic [D_WIDTH-1:0]   req_wdata,
  output logic                 resp_valid,
  output logic [D_WIDTH-1:0]   resp_rdata,
  output logic                 resp_err,
  output logic                 mem_we,
  output logic [A_WIDTH-1:0]   mem_w_addr,
  output logic [D_WIDTH-1:0]   mem_w_data,
  output logic                 mem_re,
  output logic [A_WIDTH-1:0]   mem_r_addr,
  input  logic [D_WIDTH-1:0]   mem_r_data
);

  state_e               r_state;
  logic                 r_we;
  logic [1:0]           r_size;
  logic                 r_signed;
  logic [A_WIDTH+1:0]   r_addr;
  logic [D_WIDTH-1:0]   r_wdata;   // store data, replaced by the merged word on RMW
  logic                 r_resp_valid;
  logic [D_WIDTH-1:0]   r_resp_rdata;
  logic                 r_resp_err;

  logic                 w_req_err;
  logic [D_WIDTH-1:0]   w_load;
  logic [D_WIDTH-1:0]   w_merge;

  assign w_req_err = req_is_err(req_size, req_addr[1:0]);

  lsu_lane_fmt u_fmt (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_lane   (r_addr[1:0]),
    .i_rdata  (mem_r_data),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      // Response registers default to idle so resp_valid is a single pulse
      // and resp_rdata reads zero for stores and errors.
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_req_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (req_we && (req_size == SZ_WORD)) begin
              r_state <= S_WR;
            end else begin
              // Loads and sub-word stores both need the current word first.
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (r_we) begin
            r_wdata <= w_merge;
            r_state <= S_WR;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load;
            r_state      <= S_IDLE;
          end
        end
        S_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  assign mem_re     = (r_state == S_RD);
  assign mem_we     = (r_state == S_WR);
  assign mem_r_addr = r_addr[A_WIDTH+1:2];
  assign mem_w_addr = r_addr[A_WIDTH+1:2];
  assign mem_w_data = r_wdata;

endmodule
